instr_encoder: RTL

Streaming MIPS instruction encoder and instruction-memory loader for the pipelined CPU test harness. It accepts one decoded instruction per handshake as an operation code plus register, immediate and target fields, and assembles the 32-bit machine word. Words are buffered in a small FIFO and written to consecutive word addresses of instruction memory starting at the text base. It is the inverse of the decode stage's control decoder and covers the same instruction set: addu, subu, ori, lw, sw, beq, lui, j, jal, jr, nop.

---
 rtl/instr_enc_pkg.sv | 110 +++++++++++
 rtl/instr_enc_fifo.sv | 74 +++++++
 rtl/instr_encoder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/instr_enc_pkg.sv
// Shared definitions for the MIPS instruction encoder: operation and writer
// state enums, opcode/func constants, field positions and a pure encode
// function that turns one decoded beat into a 32-bit machine word.
package instr_enc_pkg;

  // Operation codes carried on in_op; 11..15 are illegal.
  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADDU = 4'd1,
    OP_SUBU = 4'd2,
    OP_ORI  = 4'd3,
    OP_LW   = 4'd4,
    OP_SW   = 4'd5,
    OP_BEQ  = 4'd6,
    OP_LUI  = 4'd7,
    OP_J    = 4'd8,
    OP_JAL  = 4'd9,
    OP_JR   = 4'd10
  } op_e;

  // Writer state machine.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_OVF  = 2'd3
  } state_e;

  // Primary opcodes.
  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_LUI   = 6'b001111;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_JAL   = 6'b000011;

  // R-type function codes.
  localparam logic [5:0] FUNC_ADDU = 6'b100001;
  localparam logic [5:0] FUNC_SUBU = 6'b100011;
  localparam logic [5:0] FUNC_JR   = 6'b001000;

  // Field bit positions (LSB of each field).
  localparam int OPC_LSB  = 26;
  localparam int RS_LSB   = 21;
  localparam int RT_LSB   = 16;
  localparam int RD_LSB   = 11;
  localparam int FUNC_LSB = 0;
  localparam int IMM_LSB  = 0;
  localparam int TGT_LSB  = 0;

  // True for in_op values that name a supported instruction.
  function automatic logic is_legal_op(input logic [3:0] op);
    return op <= OP_JR;
  endfunction

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] func);
    logic [31:0] w;
    w = '0;
    w[OPC_LSB +: 6]  = OPC_RTYPE;
    w[RS_LSB +: 5]   = rs;
    w[RT_LSB +: 5]   = rt;
    w[RD_LSB +: 5]   = rd;
    w[FUNC_LSB +: 6] = func;
    return w;
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    logic [31:0] w;
    w = '0;
    w[OPC_LSB +: 6]  = opc;
    w[RS_LSB +: 5]   = rs;
    w[RT_LSB +: 5]   = rt;
    w[IMM_LSB +: 16] = imm;
    return w;
  endfunction

  function automatic logic [31:0] j_type(input logic [5:0] opc, input logic [25:0] target);
    logic [31:0] w;
    w = '0;
    w[OPC_LSB +: 6]  = opc;
    w[TGT_LSB +: 26] = target;
    return w;
  endfunction

  // Assemble one machine word; nop and illegal ops give all zeros.
  function automatic logic [31:0] encode(input logic [3:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [15:0] imm, input logic [25:0] target);
    logic [31:0] w;
    case (op)
      OP_ADDU: w = r_type(rs, rt, rd, FUNC_ADDU);
      OP_SUBU: w = r_type(rs, rt, rd, FUNC_SUBU);
      OP_JR:   w = r_type(rs, 5'd0, 5'd0, FUNC_JR);
      OP_ORI:  w = i_type(OPC_ORI, rs, rt, imm);
      OP_LW:   w = i_type(OPC_LW, rs, rt, imm);
      OP_SW:   w = i_type(OPC_SW, rs, rt, imm);
      OP_BEQ:  w = i_type(OPC_BEQ, rs, rt, imm);
      OP_LUI:  w = i_type(OPC_LUI, 5'd0, rt, imm);
      OP_J:    w = j_type(OPC_J, target);
      OP_JAL:  w = j_type(OPC_JAL, target);
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_enc_fifo.sv
// Synchronous FIFO holding encoded words plus their in_last flag.
// DEPTH must be a power of two (pointers wrap naturally); flush empties it.
module instr_enc_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [31:0]              push_data,
  input  logic                     push_last,
  input  logic                     pop,
  output logic [31:0]              head_data,
  output logic                     head_last,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [32:0]   mem_q [DEPTH];
  logic          do_push, do_pop;

  // Next-state for pointers and occupancy; flush wins over push/pop.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    full     = (count_q == (AW+1)'(DEPTH));
    empty    = (count_q == '0);
    do_push  = push && !full && !flush;
    do_pop   = pop && !empty && !flush;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
      else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the empty flag guards every read.
    if (do_push) mem_q[wr_ptr_q] <= {push_last, push_data};
  end

  assign head_data = mem_q[rd_ptr_q][31:0];
  assign head_last = mem_q[rd_ptr_q][32];
  assign count     = count_q;

endmodule

// File: rtl/instr_encoder.sv
// Streaming MIPS instruction encoder and instruction-memory loader.
// Beats are encoded, buffered in instr_enc_fifo and written to consecutive
// words from BASE_ADDR. Optional feature macro INSTR_ENCODER_ILLEGAL_AS_NOP_EN:
// when defined, illegal ops are written as 32'h0 instead of being dropped.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          IM_WORDS  = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  input  logic        in_last,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  input  logic        im_stall,
  output logic [10:0] words,
  output logic        done,
  output logic        err,
  output logic        ovf
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e        state_q, state_d;
  logic [10:0]   words_q, words_d;
  logic          err_q, err_d;

  logic          accept, op_legal, push, pop, flush;
  logic          write_done, at_cap, pending_after;
  logic [31:0]   enc_word;
  logic [31:0]   head_data;
  logic          head_last;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  instr_enc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data (enc_word),
    .push_last (in_last),
    .pop       (pop),
    .head_data (head_data),
    .head_last (head_last),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Handshake, encoding, memory-port drive and writer next-state.
  always_comb begin
    state_d  = state_q;
    words_d  = words_q;
    err_d    = err_q;

    in_ready = !fifo_full && (state_q != ST_DONE) && (state_q != ST_OVF) && !start;
    accept   = in_valid && in_ready;
    op_legal = is_legal_op(in_op);
    enc_word = encode(in_op, in_rs, in_rt, in_rd, in_imm, in_target);
`ifdef INSTR_ENCODER_ILLEGAL_AS_NOP_EN
    push     = accept;
`else
    push     = accept && op_legal;
`endif

    // Once the memory is full nothing more is written; pending data means overflow.
    at_cap     = (words_q >= 11'(IM_WORDS));
    im_we      = (state_q == ST_RUN) && !fifo_empty && !at_cap;
    write_done = im_we && !im_stall;
    pop        = write_done;
    flush      = start || (state_q == ST_OVF);
    im_addr    = BASE_ADDR + {19'd0, words_q, 2'b00};
    im_wdata   = fifo_empty ? 32'h0 : head_data;

    // Occupancy after this edge excluding the popped head.
    pending_after = (fifo_count > CW'(1)) || push;

    if (accept && !op_legal) err_d = 1'b1;
    if (write_done)          words_d = words_q + 11'd1;

    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN: begin
        if (write_done && head_last)
          state_d = ST_DONE;
        else if (write_done && (words_q + 11'd1 == 11'(IM_WORDS)) && pending_after)
          state_d = ST_OVF;
        else if (at_cap && !fifo_empty)
          state_d = ST_OVF;
      end
      default: state_d = state_q;
    endcase

    if (start) begin
      state_d = ST_IDLE;
      words_d = '0;
      err_d   = 1'b0;
    end
  end

  // Writer state, word counter and error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      words_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      words_q <= words_d;
      err_q   <= err_d;
    end
  end

  assign words = words_q;
  assign err   = err_q;
  assign done  = (state_q == ST_DONE);
  assign ovf   = (state_q == ST_OVF);

endmodule
